// File: rtl/sensor_poll_fmt.sv
// Periodic sensor poll scheduler: starts a sensor transaction every poll period,
// converts each channel's bytes to decimal by sequential double-dabble and drives 16-char LCD lines.
module sensor_poll_fmt #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int POLL_MS    = 1200,
   parameter int TIMEOUT_MS = 50,
   parameter int N_CH       = 2,
   parameter bit LZ_BLANK   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  sens_start,
   input  logic                  sens_done,
   input  logic                  sens_err,
   input  logic [16*N_CH-1:0]    sens_data,
   input  logic [8*N_CH-1:0]     ch_label,
   output logic [128*N_CH-1:0]   disp_bus,
   output logic                  disp_upd,
   output logic                  data_ok,
   output logic [7:0]            err_cnt
);

   localparam int POLL_CYC = CLK_HZ / 1000 * POLL_MS;
   localparam int TO_CYC   = CLK_HZ / 1000 * TIMEOUT_MS;
   localparam int NB       = 2 * N_CH;
   localparam int PW       = $clog2(POLL_CYC + 1);
   localparam int TW       = $clog2(TO_CYC + 1);
   localparam logic [7:0] CH_DASH  = 8'h2D;
   localparam logic [7:0] CH_SPACE = 8'h20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CONV,
      S_UPDATE,
      S_FAIL
   } state_t;

   state_t          state;
   logic [PW-1:0]   poll_cnt;
   logic            tick;
   logic [TW-1:0]   to_cnt;
   logic [2:0]      byte_idx;
   logic [3:0]      step;
   logic [11:0]     bcd;
   logic [11:0]     bcd_adj;
   logic [7:0]      sh;
   logic            blank_h;
   logic            blank_t;
   logic [7:0]      data_b    [8];
   logic [7:0]      shadow    [8];
   logic [7:0]      stage_dig [8][3];
   logic [7:0]      disp_dig  [8][3];

   // Byte b of the frame: even b is the integer byte of channel b/2, odd b the fraction byte.
   for (genvar b = 0; b < 8; b++) begin : g_unpack
      if (b < NB) begin : g_used
         assign data_b[b] = sens_data[16*(b/2) + ((b % 2 == 0) ? 8 : 0) +: 8];
      end else begin : g_pad
         assign data_b[b] = 8'h00;
      end
   end

   assign tick = (poll_cnt == PW'(POLL_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_cnt <= '0;
      end else if (tick) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + PW'(1);
      end
   end

   always_comb begin
      bcd_adj[3:0]   = (bcd[3:0]   >= 4'd5) ? bcd[3:0]   + 4'd3 : bcd[3:0];
      bcd_adj[7:4]   = (bcd[7:4]   >= 4'd5) ? bcd[7:4]   + 4'd3 : bcd[7:4];
      bcd_adj[11:8]  = (bcd[11:8]  >= 4'd5) ? bcd[11:8]  + 4'd3 : bcd[11:8];
      blank_h        = LZ_BLANK && !byte_idx[0] && (bcd[11:8] == 4'd0);
      blank_t        = blank_h && (bcd[7:4] == 4'd0);
   end

   // Results are staged per byte and only copied to the visible digits in UPDATE,
   // so the display never shows a partially converted frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sens_start <= 1'b0;
         disp_upd   <= 1'b0;
         data_ok    <= 1'b0;
         err_cnt    <= 8'd0;
         to_cnt     <= '0;
         byte_idx   <= 3'd0;
         step       <= 4'd0;
         bcd        <= 12'd0;
         sh         <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            shadow[i] <= 8'd0;
            for (int j = 0; j < 3; j++) begin
               stage_dig[i][j] <= CH_DASH;
               disp_dig[i][j]  <= CH_DASH;
            end
         end
      end else begin
         sens_start <= 1'b0;
         disp_upd   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (tick) begin
                  sens_start <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               to_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (sens_done) begin
                  for (int i = 0; i < 8; i++) begin
                     shadow[i] <= data_b[i];
                  end
                  sh       <= data_b[0];
                  bcd      <= 12'd0;
                  byte_idx <= 3'd0;
                  step     <= 4'd0;
                  state    <= S_CONV;
               end else if (sens_err || (to_cnt == TW'(TO_CYC - 1))) begin
                  state <= S_FAIL;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_CONV: begin
               if (step != 4'd8) begin
                  bcd  <= {bcd_adj[10:0], sh[7]};
                  sh   <= {sh[6:0], 1'b0};
                  step <= step + 4'd1;
               end else begin
                  stage_dig[byte_idx][0] <= blank_h ? CH_SPACE : {4'h3, bcd[11:8]};
                  stage_dig[byte_idx][1] <= blank_t ? CH_SPACE : {4'h3, bcd[7:4]};
                  stage_dig[byte_idx][2] <= {4'h3, bcd[3:0]};
                  step     <= 4'd0;
                  bcd      <= 12'd0;
                  sh       <= shadow[byte_idx + 3'd1];
                  byte_idx <= byte_idx + 3'd1;
                  if (byte_idx == 3'(NB - 1)) begin
                     state <= S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               for (int i = 0; i < 8; i++) begin
                  for (int j = 0; j < 3; j++) begin
                     disp_dig[i][j] <= stage_dig[i][j];
                  end
               end
               disp_upd <= 1'b1;
               data_ok  <= 1'b1;
               state    <= S_IDLE;
            end
            S_FAIL: begin
               for (int i = 0; i < 8; i++) begin
                  for (int j = 0; j < 3; j++) begin
                     disp_dig[i][j] <= CH_DASH;
                  end
               end
               if (err_cnt != 8'hFF) begin
                  err_cnt <= err_cnt + 8'd1;
               end
               disp_upd <= 1'b1;
               data_ok  <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_line
      assign disp_bus[128*c      +: 8]  = ch_label[8*c +: 8];
      assign disp_bus[128*c + 8  +: 8]  = 8'h3A;
      assign disp_bus[128*c + 16 +: 8]  = disp_dig[2*c][0];
      assign disp_bus[128*c + 24 +: 8]  = disp_dig[2*c][1];
      assign disp_bus[128*c + 32 +: 8]  = disp_dig[2*c][2];
      assign disp_bus[128*c + 40 +: 8]  = 8'h2E;
      assign disp_bus[128*c + 48 +: 8]  = disp_dig[2*c+1][0];
      assign disp_bus[128*c + 56 +: 8]  = disp_dig[2*c+1][1];
      assign disp_bus[128*c + 64 +: 8]  = disp_dig[2*c+1][2];
      assign disp_bus[128*c + 72 +: 56] = {7{CH_SPACE}};
   end

endmodule

// File: doc/sensor_poll_fmt.md
Name: sensor_poll_fmt

Overview:
Periodic sensor poll scheduler with an ASCII formatter for N_CH channels, one 16-character LCD line per channel. Every POLL_MS it starts a sensor transaction and waits for done, error or timeout. It converts each channel's integer and fraction bytes to decimal with a sequential double-dabble and registers an ASCII line buffer for the lcd1602 driver. It supersedes the fixed free-running reset counter and the combinational /,% digit logic in the top level.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
POLL_MS, 1200, poll period in ms; POLL_CYC = CLK_HZ/1000*POLL_MS
TIMEOUT_MS, 50, max wait for sens_done/sens_err; TO_CYC = CLK_HZ/1000*TIMEOUT_MS
N_CH, 2, number of channels (1..4)
LZ_BLANK, 0, 1 = leading integer zeros shown as space (units digit always shown)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sens_start  out  1  one-cycle start pulse to the sensor reader
sens_done  in  1  one-cycle pulse; sens_data valid this cycle
sens_err  in  1  one-cycle pulse; transaction failed (checksum/protocol)
sens_data  in  16*N_CH  channel c: [16c+15:16c+8] integer byte, [16c+7:16c] fraction byte
ch_label  in  8*N_CH  ASCII label char per channel, quasi-static
disp_bus  out  128*N_CH  char k of channel c at [8(16c+k)+7 : 8(16c+k)]
disp_upd  out  1  one-cycle pulse when disp_bus digits change
data_ok  out  1  1 = last transaction succeeded
err_cnt  out  8  failed or timed-out transactions, saturating at 255

Behaviour:
- Reset values: sens_start=0, disp_upd=0, data_ok=0, err_cnt=0. All digit registers are 0x2D ('-'). FSM is in IDLE. Poll and timeout counters are 0.
- Line layout per channel:
  - char0 = label, char1 = ':', chars2-4 = integer hundreds/tens/units, char5 = '.', chars6-8 = fraction hundreds/tens/units, chars9-15 = 0x20.
  - Label, ':', '.' and spaces are combinational from inputs/constants. Digits are registered.
- Poll counter runs continuously from reset and wraps at POLL_CYC-1, producing a tick. The first tick comes POLL_CYC cycles after reset release.
- A tick seen outside IDLE is dropped. No queueing.
- FSM states:
  - IDLE: on tick go to START.
  - START: sens_start=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: priority is sens_done > sens_err > timeout.
    - sens_done: capture sens_data into a shadow register, go to CONV.
    - sens_err, or timeout counter reaching TO_CYC-1: go to FAIL.
  - CONV: bytes are processed in order ch0 int, ch0 frac, ch1 int, ...
    - Each byte takes 8 shift cycles: add 3 to any BCD nibble >=5, then shift left 1. A 9th cycle stores the three ASCII digits (0x30+nibble).
    - Total 18*N_CH cycles, then go to UPDATE.
  - UPDATE: commit all staged digits in one cycle, disp_upd=1, data_ok=1, go to IDLE.
  - FAIL: all digits set to '-', data_ok=0, err_cnt+1 (saturating), disp_upd=1, go to IDLE.
- Staged digits are not visible on disp_bus until UPDATE, so the display never shows a partial frame.
- Leading zeros with LZ_BLANK=1:
  - integer hundreds '0' becomes ' ';
  - integer tens '0' becomes ' ' only if hundreds was also blanked;
  - fraction digits are never blanked.
- Byte range is 0..255. 255 renders "255". No overflow is possible in 12-bit BCD.
- sens_done and sens_err outside WAIT are ignored. Both in the same WAIT cycle means done wins.
- rst_n asserted mid-transaction returns everything to reset values immediately (async). No sens_start is issued until the next tick after release.

Test Plan:
1. CLK_HZ=1000, POLL_MS=20, N_CH=2, LZ_BLANK=0, labels "T","H". Release reset -> sens_start pulses at cycle 20, 40, 60 after release, each exactly 1 cycle wide.
2. sens_done 3 cycles after start with data ch0={25,6}, ch1={60,0} -> disp_upd exactly 36+1 cycles after done. Line0 = "T:025.006       ", line1 = "H:060.000       ", data_ok=1.
3. LZ_BLANK=1, ch0={7,5}, ch1={255,100} -> "T:  7.005", "H:255.100". Data {100,0} -> "100.000"; data {0,0} -> "  0.000".
4. No response after sens_start -> FAIL after TO_CYC cycles, all digits '-', data_ok=0, err_cnt=1. The next good poll restores digits and data_ok=1.
5. Assert sens_err 260 times -> err_cnt stays 255. sens_done and sens_err in the same WAIT cycle -> treated as success.
6. Pull rst_n low during CONV -> disp_bus digits '-', disp_upd=0, sens_start=0. Pulse sens_done while in IDLE -> no disp_upd and digits unchanged.
